riscv_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller between the SC_RISCV data-memory port and the external INPUT/OUTPUT streams. It decodes three word addresses, buffers inbound and outbound words in two FIFOs with valid/ready handshakes, and stalls the core whenever an I/O access cannot complete. It replaces the core's direct INPUT/OUTPUT wiring so software reads and writes the outside world with plain lw/sw instructions.

---
 rtl/riscv_mmio_ctrl.sv | 147 ++++++++++++++
 tb/tb_riscv_mmio_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_ctrl.sv
// Memory-mapped I/O bridge between the core data port and inbound/outbound word streams.
// Optional stall-abort watchdog is compiled in with MMIO_TIMEOUT_EN.
module riscv_mmio_ctrl #(
    parameter logic [31:0] ADDR_IN   = 32'h0000_0100,
    parameter logic [31:0] ADDR_OUT  = 32'h0000_0104,
    parameter logic [31:0] ADDR_STAT = 32'h0000_0108,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        stall,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshakes: a word moves on a rising edge where valid && ready are both high;
    // valid never waits on ready, and ready comes only from registered FIFO state.

    logic ld_in, st_out, ld_stat;
    logic want_stall, abort, stall_int, err;

    logic [31:0]   in_mem [DEPTH];
    logic [AW-1:0] in_wp, in_rp;
    logic [CW-1:0] in_cnt;
    logic          in_empty, in_full, in_push, in_pop;

    logic [31:0]   out_mem [DEPTH];
    logic [AW-1:0] out_wp, out_rp;
    logic [CW-1:0] out_cnt;
    logic          out_empty, out_full, out_push, out_pop;

    logic [31:0] status;

    // A simultaneous load and store strobe is decoded as a store only.
    assign ld_in   = mem_re && !mem_we && (mem_addr == ADDR_IN);
    assign ld_stat = mem_re && !mem_we && (mem_addr == ADDR_STAT);
    assign st_out  = mem_we && (mem_addr == ADDR_OUT);

    assign in_empty  = (in_cnt == '0);
    assign in_full   = (in_cnt == FULL_CNT);
    assign out_empty = (out_cnt == '0);
    assign out_full  = (out_cnt == FULL_CNT);

    assign want_stall = (ld_in && in_empty) || (st_out && out_full);
    assign stall_int  = want_stall && !abort;
    assign stall      = rst && stall_int;

    assign in_ready = rst && !in_full;
    assign in_push  = in_valid && in_ready;
    assign in_pop   = ld_in && !in_empty;

    assign out_valid = !out_empty;
    assign out_data  = out_empty ? 32'h0 : out_mem[out_rp];
    assign out_pop   = out_valid && out_ready;
    assign out_push  = st_out && !out_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wp  <= '0;
            in_rp  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + AW'(1);
            if (in_pop)  in_rp <= in_rp + AW'(1);
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + CW'(1);
                2'b01:   in_cnt <= in_cnt - CW'(1);
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wp  <= '0;
            out_rp  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_push) out_wp <= out_wp + AW'(1);
            if (out_pop)  out_rp <= out_rp + AW'(1);
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (out_push) out_mem[out_wp] <= mem_wdata;
    end

`ifdef MMIO_TIMEOUT_EN
    logic [15:0] tcnt;

    // Abort only ever fires while the blocking FIFO condition holds, so the
    // pop/push enables above already suppress the aborted access.
    assign abort = want_stall && (tcnt == TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= stall_int ? tcnt + 16'd1 : 16'd0;
            if (abort)        err <= 1'b1;
            else if (ld_stat) err <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign status = {8'h00, 8'(out_cnt), 8'(in_cnt), 3'b000,
                     err, out_full, out_empty, in_full, in_empty};

    always_comb begin
        mem_rdata = 32'h0;
        if (rst) begin
            if (in_pop)       mem_rdata = in_mem[in_rp];
            else if (ld_stat) mem_rdata = status;
        end
    end

endmodule

// File: tb/tb_riscv_mmio_ctrl.sv
// Self-checking bench for riscv_mmio_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_riscv_mmio_ctrl;

  localparam int          DEPTH = 4;
  localparam int          TO    = 16;
  localparam logic [31:0] A_IN  = 32'h0000_0100;
  localparam logic [31:0] A_OUT = 32'h0000_0104;
  localparam logic [31:0] A_ST  = 32'h0000_0108;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  logic        exp_err;
  int          tc;

  riscv_mmio_ctrl #(
    .ADDR_IN(A_IN), .ADDR_OUT(A_OUT), .ADDR_STAT(A_ST),
    .DEPTH(DEPTH), .TIMEOUT(16'(TO))
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .stall(stall),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic re, input logic [31:0] wd);
    mem_addr  = a;
    mem_we    = we;
    mem_re    = re;
    mem_wdata = wd;
  endtask

  task automatic idle_core;
    drive(32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset;
    idle_core();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] exp_status(int ic, int oc, logic e);
    return {8'h00, 8'(oc), 8'(ic), 3'b000, e, oc == DEPTH, oc == 0, ic == DEPTH, ic == 0};
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    drive(A_IN, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
      step();
    end
    in_valid = 1'b0;
    idle_core();
    rst = 1'b1;
    drive(A_ST, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0000_0005) begin errors++; $display("FAIL reset_status got %h want 00000005", mem_rdata); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    step();
    idle_core();
  endtask

  task automatic test_input_stream;
    logic [31:0] vals [4];
    vals = '{32'd20, 32'd25, 32'd15, 32'd40};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_fill%0d got %0b want 1", i, in_ready); end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_full got %0b want 0", in_ready); end
    step();
    drive(A_IN, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL in_read_stall%0d got %0b want 0", i, stall); end
      checks++; if (mem_rdata !== vals[i]) begin errors++; $display("FAIL in_read%0d got %0d want %0d", i, mem_rdata, vals[i]); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_empty_stall%0d got %0b want 1", i, stall); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL in_empty_rdata%0d got %h want 0", i, mem_rdata); end
      step();
    end
    in_valid = 1'b1;
    in_data  = 32'd7;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_arrive_stall got %0b want 1", stall); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL in_late_stall got %0b want 0", stall); end
    checks++; if (mem_rdata !== 32'd7) begin errors++; $display("FAIL in_late_rdata got %0d want 7", mem_rdata); end
    step();
    idle_core();
  endtask

  task automatic test_output_backpressure;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(A_OUT, 1'b1, 1'b0, 32'(i));
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL out_store_stall%0d got %0b want 0", i, stall); end
      step();
    end
    drive(A_OUT, 1'b1, 1'b0, 32'd5);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL out_full_stall got %0b want 1", stall); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin errors++; $display("FAIL out_head got %0b/%0d want 1/1", out_valid, out_data); end
    step();
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL out_full_stall2 got %0b want 1", stall); end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL out_ready_same_cycle got %0b want 1", stall); end
    step();
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL out_store_done got %0b want 0", stall); end
    checks++; if (out_data !== 32'd2) begin errors++; $display("FAIL out_drain2 got %0d want 2", out_data); end
    step();
    idle_core();
    for (int v = 3; v <= 5; v++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(v)) begin errors++; $display("FAIL out_drain%0d got %0b/%0d want 1/%0d", v, out_valid, out_data, v); end
      step();
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL out_empty got %0b/%h want 0/0", out_valid, out_data); end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_simultaneous;
    do_reset();
    in_valid = 1'b1;
    in_data  = 32'd11;
    step();
    in_data = 32'd22;
    drive(A_IN, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_rdata !== 32'd11) begin errors++; $display("FAIL simul_read got %0b/%0d want 0/11", stall, mem_rdata); end
    step();
    in_valid = 1'b0;
    drive(A_ST, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0000_0104) begin errors++; $display("FAIL simul_status got %h want 00000104", mem_rdata); end
    step();
    drive(A_IN, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'd22) begin errors++; $display("FAIL simul_order got %0d want 22", mem_rdata); end
    step();
    idle_core();
  endtask

  task automatic test_status_decode;
    do_reset();
    in_valid = 1'b1;
    in_data = 32'hA1;
    step();
    in_data = 32'hA2;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(A_OUT, 1'b1, 1'b0, $urandom);
      step();
    end
    drive(A_ST, 1'b1, 1'b0, $urandom);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL dec_sw_stat got %0b/%h want 0/0", stall, mem_rdata); end
    step();
    drive(32'h0000_0200, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL dec_unmapped got %0b/%h want 0/0", stall, mem_rdata); end
    step();
    drive(A_OUT, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL dec_lw_out got %0b/%h want 0/0", stall, mem_rdata); end
    step();
    drive(A_IN, 1'b1, 1'b0, $urandom);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL dec_sw_in got %0b/%h want 0/0", stall, mem_rdata); end
    step();
    drive(A_IN, 1'b1, 1'b1, $urandom);
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL dec_we_re got %0b/%h want 0/0", stall, mem_rdata); end
    step();
    drive(A_ST, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0003_0200) begin errors++; $display("FAIL dec_status got %h want 00030200", mem_rdata); end
    step();
    drive(A_IN, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'hA1) begin errors++; $display("FAIL dec_head got %h want a1", mem_rdata); end
    step();
    idle_core();
  endtask

  task automatic test_timeout;
    int  cnt;
    bit  done;
    int  limit;
    cnt = 0;
    done = 0;
`ifdef MMIO_TIMEOUT_EN
    limit = 100;
`else
    limit = 40;
`endif
    do_reset();
    drive(A_IN, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < limit && !done; k++) begin
      @(negedge clk);
      if (stall) begin
        cnt++;
        step();
      end else begin
        done = 1;
      end
    end
`ifdef MMIO_TIMEOUT_EN
    checks++; if (cnt != TO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", cnt, TO); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata got %h want 0", mem_rdata); end
    step();
    drive(A_ST, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0000_0015) begin errors++; $display("FAIL timeout_err_set got %h want 00000015", mem_rdata); end
    step();
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0000_0005) begin errors++; $display("FAIL timeout_err_clr got %h want 00000005", mem_rdata); end
    step();
`else
    checks++; if (cnt != limit) begin errors++; $display("FAIL hold_stall_cycles got %0d want %0d", cnt, limit); end
    idle_core();
    drive(A_ST, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0000_0005) begin errors++; $display("FAIL hold_status got %h want 00000005", mem_rdata); end
    step();
`endif
    idle_core();
  endtask

  // randomized traffic scored against queue model (in_q inbound, exp_q outbound)
  task automatic test_random;
    do_reset();
    in_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
    tc = 0;
    for (int n = 0; n < 600; n++) begin
      int          r, op;
      logic [31:0] wd, e_rd, e_od;
      logic        want, abort, e_stall, push_in, pop_in, push_out, pop_out;
      r  = $urandom_range(0, 9);
      op = (r <= 2) ? 1 : (r <= 4) ? 2 : (r - 2);
      wd = $urandom;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      case (op)
        1: drive(A_IN, 1'b0, 1'b1, wd);
        2: drive(A_OUT, 1'b1, 1'b0, wd);
        3: drive(A_ST, 1'b0, 1'b1, wd);
        4: drive(32'h0000_0200 + 32'($urandom_range(0, 63)) * 4, 1'b0, 1'b1, wd);
        5: drive(A_OUT, 1'b1, 1'b1, wd);
        6: drive(A_ST, 1'b1, 1'b0, wd);
        default: drive(A_OUT, 1'b0, 1'b1, wd);
      endcase
      want = (op == 1 && in_q.size() == 0) || ((op == 2 || op == 5) && exp_q.size() == DEPTH);
`ifdef MMIO_TIMEOUT_EN
      abort = want && (tc == TO);
`else
      abort = 1'b0;
`endif
      e_stall = want && !abort;
      e_rd = 32'h0;
      if (op == 1 && in_q.size() > 0) e_rd = in_q[0];
      if (op == 3) e_rd = exp_status(in_q.size(), exp_q.size(), exp_err);
      e_od = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
      push_in  = in_valid && (in_q.size() < DEPTH);
      pop_in   = (op == 1) && (in_q.size() > 0);
      push_out = (op == 2 || op == 5) && (exp_q.size() < DEPTH);
      pop_out  = out_ready && (exp_q.size() > 0);
      @(negedge clk);
      checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %0b want %0b", n, stall, e_stall); end
      checks++; if (mem_rdata !== e_rd) begin errors++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, mem_rdata, e_rd); end
      checks++; if (in_ready !== (in_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready n=%0d got %0b want %0b", n, in_ready, in_q.size() < DEPTH); end
      checks++; if (out_valid !== (exp_q.size() > 0) || out_data !== e_od) begin errors++; $display("FAIL rnd_out n=%0d got %0b/%h want %0b/%h", n, out_valid, out_data, exp_q.size() > 0, e_od); end
      @(posedge clk);
      if (pop_in) void'(in_q.pop_front());
      if (push_in) in_q.push_back(in_data);
      if (pop_out) void'(exp_q.pop_front());
      if (push_out) exp_q.push_back(wd);
      if (abort) exp_err = 1'b1;
      else if (op == 3) exp_err = 1'b0;
      tc = e_stall ? tc + 1 : 0;
      #1;
    end
    idle_core();
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_input_stream();
    test_output_backpressure();
    test_simultaneous();
    test_status_decode();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
